// File: rtl/phy_rx_pkg.sv
// -----------------------------------------------------------------------------
// phy_rx_pkg
//
// Shared definitions for the serial-to-parallel comma-aligned receiver.
//
// Contents:
//   rx_state_e   - alignment FSM states (SEARCH, ALIGN, LOCKED)
//   COM_DEFAULT  - default comma/idle symbol (8'hBC)
//   BCNT_W       - width of the bit-in-byte counter
//   CCNT_W       - width of the consecutive-COM counter
//   is_boundary  - true when the current edge completes an aligned byte
// -----------------------------------------------------------------------------
package phy_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    localparam logic [7:0] COM_DEFAULT = 8'hBC;
    localparam int         BCNT_W      = 3;
    localparam int         CCNT_W      = 4;

    // Outside SEARCH the bit counter tracks the byte phase; the edge on which
    // it reads 7 is the one whose incoming bit completes a byte.
    function automatic logic is_boundary(input rx_state_e st,
                                         input logic [BCNT_W-1:0] bcnt);
        return (st != SEARCH) && (bcnt == BCNT_W'(7));
    endfunction

endpackage : phy_rx_pkg

// File: rtl/com_align_fsm.sv
// -----------------------------------------------------------------------------
// com_align_fsm
//
// Byte-alignment state machine. Hunts for a comma at any bit offset, then
// requires LOCK_COUNT consecutive commas on the same byte phase before
// declaring lock.
//
// Optional feature (macro SERIAL_RX_LOSS_DET_EN): while locked, count
// consecutive non-comma bytes and fall back to SEARCH when LOSS_GAP of them
// arrive in a row. Without the macro, lock is only left through reset.
//
// Ports:
//   clk          in   bit-rate clock
//   rst_n        in   asynchronous active-low reset
//   com_match_i  in   candidate byte for this edge equals the comma symbol
//   boundary_o   out  this edge completes an aligned byte (combinational)
//   locked_o     out  registered, high while in LOCKED
// -----------------------------------------------------------------------------
module com_align_fsm
    import phy_rx_pkg::*;
#(
    parameter int LOCK_COUNT = 4
`ifdef SERIAL_RX_LOSS_DET_EN
    ,
    parameter int LOSS_GAP   = 16
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic com_match_i,
    output logic boundary_o,
    output logic locked_o
);

    localparam logic [CCNT_W-1:0] LOCK_CNT_C = CCNT_W'(LOCK_COUNT);

    rx_state_e         state_q;
    logic [BCNT_W-1:0] bcnt_q;
    logic [CCNT_W-1:0] ccnt_q;
    logic              locked_q;

`ifdef SERIAL_RX_LOSS_DET_EN
    localparam int            GAP_W     = $clog2(LOSS_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(LOSS_GAP);
    logic [GAP_W-1:0] gap_q;
`endif

    assign boundary_o = is_boundary(state_q, bcnt_q);
    assign locked_o   = locked_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            bcnt_q   <= '0;
            ccnt_q   <= '0;
            locked_q <= 1'b0;
`ifdef SERIAL_RX_LOSS_DET_EN
            gap_q    <= '0;
`endif
        end else begin
            case (state_q)
                SEARCH: begin
                    // Every bit offset is a candidate until a comma is seen;
                    // that comma defines the byte phase from here on.
                    if (com_match_i) begin
                        bcnt_q <= '0;
                        ccnt_q <= CCNT_W'(1);
                        if (LOCK_COUNT == 1) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
`ifdef SERIAL_RX_LOSS_DET_EN
                            gap_q    <= '0;
`endif
                        end else begin
                            state_q <= ALIGN;
                        end
                    end
                end

                ALIGN: begin
                    bcnt_q <= bcnt_q + BCNT_W'(1);
                    // Only boundary edges are examined, so a comma pattern
                    // straddling two bytes cannot disturb the phase.
                    if (boundary_o) begin
                        if (com_match_i) begin
                            ccnt_q <= ccnt_q + CCNT_W'(1);
                            if (ccnt_q + CCNT_W'(1) == LOCK_CNT_C) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
`ifdef SERIAL_RX_LOSS_DET_EN
                                gap_q    <= '0;
`endif
                            end
                        end else begin
                            state_q <= SEARCH;
                            ccnt_q  <= '0;
                        end
                    end
                end

                LOCKED: begin
                    bcnt_q <= bcnt_q + BCNT_W'(1);
`ifdef SERIAL_RX_LOSS_DET_EN
                    if (boundary_o) begin
                        if (com_match_i) begin
                            gap_q <= '0;
                        end else if (gap_q + GAP_W'(1) == GAP_LIMIT) begin
                            // Too long without a comma: assume the phase is
                            // stale and hunt again.
                            state_q  <= SEARCH;
                            locked_q <= 1'b0;
                            ccnt_q   <= '0;
                            gap_q    <= '0;
                        end else begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end
`endif
                end

                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                    ccnt_q   <= '0;
                end
            endcase
        end
    end

endmodule : com_align_fsm

// File: rtl/serial_to_parallel_rx.sv
// -----------------------------------------------------------------------------
// serial_to_parallel_rx
//
// Deserialises an MSB-first bit stream into bytes, aligning on a comma symbol
// (COM). Commas are consumed for alignment and never presented as data.
//
// Optional feature (macro SERIAL_RX_LOSS_DET_EN): lock is dropped after
// LOSS_GAP consecutive non-comma bytes. Default build: lock held until reset.
//
// Parameters:
//   COM         comma/idle symbol (default 8'hBC)
//   LOCK_COUNT  consecutive aligned commas needed to lock (1..15)
//   LOSS_GAP    non-comma bytes in a row that drop lock (loss detection only)
//
// Ports:
//   clk        in   bit-rate clock, all state on its rising edge
//   reset      in   asynchronous active-low reset
//   data_in    in   serial data, MSB of each byte first
//   data_out   out  last received non-comma byte (held between strobes)
//   valid_out  out  one-cycle strobe marking a new byte on data_out
//   active     out  high while the aligner is locked
// -----------------------------------------------------------------------------
module serial_to_parallel_rx
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COM        = COM_DEFAULT,
    parameter int         LOCK_COUNT = 4,
    parameter int         LOSS_GAP   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    // Seven history bits plus the incoming bit form the candidate byte, so a
    // completed byte is usable on the same edge as its last bit.
    logic [6:0] sr_q;
    logic [6:0] sr_d;
    logic [7:0] nxt;
    logic       com_match;

    logic       boundary;
    logic       locked;
    logic       load;

    logic [7:0] data_q;
    logic [7:0] data_d;
    logic       valid_q;
    logic       valid_d;

    assign nxt       = {sr_q, data_in};
    assign com_match = (nxt == COM);

    com_align_fsm #(
        .LOCK_COUNT (LOCK_COUNT)
`ifdef SERIAL_RX_LOSS_DET_EN
        ,
        .LOSS_GAP   (LOSS_GAP)
`endif
    ) u_align (
        .clk         (clk),
        .rst_n       (reset),
        .com_match_i (com_match),
        .boundary_o  (boundary),
        .locked_o    (locked)
    );

    // A byte is delivered only on an aligned boundary while locked, and only
    // when it is not a comma.
    assign load = locked && boundary && !com_match;

    always_comb begin
        sr_d    = nxt[6:0];
        data_d  = data_q;
        valid_d = load;
        if (load) begin
            data_d = nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = locked;

endmodule : serial_to_parallel_rx

// File: tb/tb_serial_to_parallel_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_to_parallel_rx
//
// Directed self-checking bench for serial_to_parallel_rx. Bits are driven on
// the falling edge and outputs sampled 1 ns after each rising edge. Expected
// lock-loss behaviour follows the SERIAL_RX_LOSS_DET_EN macro.
// -----------------------------------------------------------------------------
module tb_serial_to_parallel_rx;

    logic       clk;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int tests_run    = 0;
    int tests_failed = 0;

    serial_to_parallel_rx dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One serial bit: drive on falling edge, sample just after rising edge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        data_in = b;
        @(posedge clk);
        #1;
    endtask

    // One byte MSB first; reports strobes seen during the byte and the
    // output state after its last bit.
    task automatic send_byte(input logic [7:0] b, output int vcnt,
                             output logic v_last, output logic [7:0] d_last,
                             output logic a_last);
        vcnt = 0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (valid_out) vcnt++;
        end
        v_last = valid_out;
        d_last = data_out;
        a_last = active;
        $display("[TB] byte %02h  strobes=%0d valid=%b data_out=%02h active=%b",
                 b, vcnt, v_last, d_last, a_last);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        data_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic send_coms(input int n, output int vtotal, output logic a_last);
        int v; logic vl; logic [7:0] d;
        vtotal = 0;
        a_last = 1'b0;
        for (int i = 0; i < n; i++) begin
            send_byte(8'hBC, v, vl, d, a_last);
            vtotal += v;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            data_in = i[0];
            @(posedge clk);
            #1;
            tests_run++;
            if ({data_out, valid_out, active} !== 10'h000) begin
                tests_failed++;
                $display("FAIL reset_hold cycle %0d: data_out=%02h valid=%b active=%b, need 00/0/0",
                         i, data_out, valid_out, active);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_aligned_lock();
        int v; int vt; logic vl; logic [7:0] d; logic a;
        do_reset();
        send_coms(3, vt, a);
        tests_run++;
        if (a !== 1'b0) begin
            tests_failed++;
            $display("FAIL aligned_active_after_24: active=%b, need 0", a);
        end
        send_byte(8'hBC, v, vl, d, a);
        vt += v;
        tests_run++;
        if (a !== 1'b1) begin
            tests_failed++;
            $display("FAIL aligned_active_bit32: active=%b, need 1", a);
        end
        tests_run++;
        if (vt !== 0) begin
            tests_failed++;
            $display("FAIL aligned_no_strobe_on_com: strobes=%0d, need 0", vt);
        end
        send_byte(8'hAA, v, vl, d, a);
        tests_run++;
        if (v !== 1 || vl !== 1'b1 || d !== 8'hAA) begin
            tests_failed++;
            $display("FAIL aligned_byte_AA: strobes=%0d last_valid=%b data=%02h, need 1/1/AA", v, vl, d);
        end
        send_byte(8'h55, v, vl, d, a);
        tests_run++;
        if (v !== 1 || vl !== 1'b1 || d !== 8'h55) begin
            tests_failed++;
            $display("FAIL aligned_byte_55: strobes=%0d last_valid=%b data=%02h, need 1/1/55", v, vl, d);
        end
        // A comma while locked is swallowed and data_out holds.
        send_byte(8'hBC, v, vl, d, a);
        tests_run++;
        if (v !== 0 || d !== 8'h55 || a !== 1'b1) begin
            tests_failed++;
            $display("FAIL locked_com_hold: strobes=%0d data=%02h active=%b, need 0/55/1", v, d, a);
        end
    endtask

    task automatic test_shifted_lock();
        int v; int vt; logic vl; logic [7:0] d; logic a;
        do_reset();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_coms(4, vt, a);
        tests_run++;
        if (a !== 1'b1 || vt !== 0) begin
            tests_failed++;
            $display("FAIL shifted_lock: active=%b strobes=%0d, need 1/0", a, vt);
        end
        send_byte(8'h77, v, vl, d, a);
        tests_run++;
        if (v !== 1 || vl !== 1'b1 || d !== 8'h77) begin
            tests_failed++;
            $display("FAIL shifted_byte_77: strobes=%0d last_valid=%b data=%02h, need 1/1/77", v, vl, d);
        end
    endtask

    task automatic test_abort();
        int v; int vt; logic vl; logic [7:0] d; logic a;
        do_reset();
        send_coms(3, vt, a);
        send_byte(8'h12, v, vl, d, a);
        vt += v;
        tests_run++;
        if (a !== 1'b0 || vt !== 0) begin
            tests_failed++;
            $display("FAIL abort_at_12: active=%b strobes=%0d, need 0/0", a, vt);
        end
        // Already back in SEARCH: a fourth-position comma does not lock.
        send_byte(8'hBC, v, vl, d, a);
        vt = v;
        send_byte(8'h34, v, vl, d, a);
        vt += v;
        tests_run++;
        if (a !== 1'b0 || vt !== 0 || d !== 8'h00) begin
            tests_failed++;
            $display("FAIL abort_stays_unlocked: active=%b strobes=%0d data=%02h, need 0/0/00", a, vt, d);
        end
    endtask

    task automatic test_reset_mid_byte();
        int v; int vt; logic vl; logic [7:0] d; logic a;
        do_reset();
        send_coms(4, vt, a);
        send_byte(8'h99, v, vl, d, a);
        tests_run++;
        if (v !== 1 || d !== 8'h99) begin
            tests_failed++;
            $display("FAIL midrst_pre_byte: strobes=%0d data=%02h, need 1/99", v, d);
        end
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        // Assert reset between clock edges; outputs must clear without a clock.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({data_out, valid_out, active} !== 10'h000) begin
            tests_failed++;
            $display("FAIL midrst_async_clear: data_out=%02h valid=%b active=%b, need 00/0/0",
                     data_out, valid_out, active);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send_byte(8'h33, v, vl, d, a);
        tests_run++;
        if (v !== 0 || a !== 1'b0 || d !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_needs_relock: strobes=%0d active=%b data=%02h, need 0/0/00", v, a, d);
        end
        send_coms(4, vt, a);
        send_byte(8'h44, v, vl, d, a);
        tests_run++;
        if (v !== 1 || vl !== 1'b1 || d !== 8'h44 || a !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_relock_44: strobes=%0d valid=%b data=%02h active=%b, need 1/1/44/1",
                     v, vl, d, a);
        end
    endtask

    task automatic test_back_to_back_gap();
        int v; int vt; logic vl; logic [7:0] d; logic a; logic a_exp;
        do_reset();
        send_coms(4, vt, a);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h5A, v, vl, d, a);
`ifdef SERIAL_RX_LOSS_DET_EN
            a_exp = (i == 15) ? 1'b0 : 1'b1;
`else
            a_exp = 1'b1;
`endif
            tests_run++;
            if (v !== 1 || vl !== 1'b1 || d !== 8'h5A || a !== a_exp) begin
                tests_failed++;
                $display("FAIL gap_byte %0d: strobes=%0d valid=%b data=%02h active=%b, need 1/1/5A/%b",
                         i, v, vl, d, a, a_exp);
            end
        end
        send_byte(8'h00, v, vl, d, a);
        tests_run++;
`ifdef SERIAL_RX_LOSS_DET_EN
        if (v !== 0 || d !== 8'h5A || a !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_after_loss: strobes=%0d data=%02h active=%b, need 0/5A/0", v, d, a);
        end
`else
        if (v !== 1 || d !== 8'h00 || a !== 1'b1) begin
            tests_failed++;
            $display("FAIL gap_still_locked: strobes=%0d data=%02h active=%b, need 1/00/1", v, d, a);
        end
`endif
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 1'b0;
        #1;
        reset = 1'b0;
        test_reset();
        test_aligned_lock();
        test_shifted_lock();
        test_abort();
        test_reset_mid_byte();
        test_back_to_back_gap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_serial_to_parallel_rx
